ysyx_23060221_axi_arb_n: RTL and testbench

Parametrised N-master to 1-slave AXI4 arbiter. It sits between the core's bus masters (IFU, LSU, and later DMA or debug) and the single `io_master` port. Each grant is locked for a whole transaction: AW/W/B for a write, AR/R through the final beat for a read. The next winner is chosen either by round-robin or by fixed priority.

---
 rtl/ysyx_23060221_axi_pkg.sv | 37 +++
 rtl/ysyx_23060221_axi_arb_n_if.sv | 34 +++
 rtl/ysyx_23060221_rr_pick.sv | 25 ++
 rtl/ysyx_23060221_axi_arb_n.sv | 142 ++++++++++++++
 tb/tb_ysyx_23060221_axi_arb_n.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060221_axi_pkg.sv
// Shared types and payload-width helpers for the N:1 AXI4 arbiter.
// AW/AR payload is {id,len,size,burst,addr}; W {last,strb,data}; B {id,resp}; R {id,last,resp,data}.
package ysyx_23060221_axi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } axi_state_e;

   localparam int LEN_W   = 8;
   localparam int SIZE_W  = 3;
   localparam int BURST_W = 2;
   localparam int RESP_W  = 2;

   function automatic int awp_w(input int idw, input int aw);
      return idw + LEN_W + SIZE_W + BURST_W + aw;
   endfunction

   function automatic int wp_w(input int dw);
      return 1 + dw / 8 + dw;
   endfunction

   function automatic int bp_w(input int idw);
      return idw + RESP_W;
   endfunction

   function automatic int rp_w(input int idw, input int dw);
      return idw + 1 + RESP_W + dw;
   endfunction

   // Bit position of rlast inside an R payload.
   function automatic int r_last_bit(input int dw);
      return dw + RESP_W;
   endfunction

endpackage

// File: rtl/ysyx_23060221_axi_arb_n_if.sv
// Bundle of L parallel AXI4 channel sets (flat vectors, lane i in slice i).
// The master modport drives requests; the slave modport drives responses.
interface ysyx_23060221_axi_arb_n_if #(
   parameter int L   = 1,
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int IDW = 4
);
   localparam int AWP = ysyx_23060221_axi_pkg::awp_w(IDW, AW);
   localparam int WP  = ysyx_23060221_axi_pkg::wp_w(DW);
   localparam int BP  = ysyx_23060221_axi_pkg::bp_w(IDW);
   localparam int RP  = ysyx_23060221_axi_pkg::rp_w(IDW, DW);

   logic [L-1:0]     awvalid, awready;
   logic [L*AWP-1:0] aw;
   logic [L-1:0]     wvalid, wready;
   logic [L*WP-1:0]  w;
   logic [L-1:0]     bvalid, bready;
   logic [L*BP-1:0]  b;
   logic [L-1:0]     arvalid, arready;
   logic [L*AWP-1:0] ar;
   logic [L-1:0]     rvalid, rready;
   logic [L*RP-1:0]  r;

   modport master (
      output awvalid, aw, wvalid, w, bready, arvalid, ar, rready,
      input  awready, wready, bvalid, b, arready, rvalid, r
   );

   modport slave (
      input  awvalid, aw, wvalid, w, bready, arvalid, ar, rready,
      output awready, wready, bvalid, b, arready, rvalid, r
   );
endinterface

// File: rtl/ysyx_23060221_rr_pick.sv
// Round-robin picker: first requester at or after ptr_i, wrapping N-1 -> 0.
module ysyx_23060221_rr_pick #(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o
);
   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(ptr_i) + k) % N);
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/ysyx_23060221_axi_arb_n.sv
// N-master to 1-slave AXI4 arbiter; one whole transaction per grant, pure combinational forwarding.
// Define YSYX_ARB_RR_EN for round-robin arbitration; otherwise the lowest index always wins.
//   state | meaning
//   IDLE  | no owner, arbitrate among requesters
//   WR    | owner's AW/W/B routed to slave, leave on B handshake
//   RD    | owner's AR/R routed to slave, leave on last R handshake
module ysyx_23060221_axi_arb_n
   import ysyx_23060221_axi_pkg::*;
#(
   parameter int N   = 2,
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int IDW = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   ysyx_23060221_axi_arb_n_if.slave    m,
   ysyx_23060221_axi_arb_n_if.master   s,
   output logic [N-1:0]                grant,
   output logic                        busy
);
   localparam int AWP   = awp_w(IDW, AW);
   localparam int WP    = wp_w(DW);
   localparam int BP    = bp_w(IDW);
   localparam int RP    = rp_w(IDW, DW);
   localparam int RLAST = r_last_bit(DW);

   axi_state_e   state_q;
   logic [N-1:0] grant_q;
   logic         busy_q;
   logic [N-1:0] req;
   logic [N-1:0] pick;
   logic         done;

   assign req = m.awvalid | m.arvalid;
   assign done = (state_q == WR) ? (s.bvalid[0] & s.bready[0])
               : (state_q == RD) ? (s.rvalid[0] & s.rready[0] & s.r[RLAST])
               : 1'b0;

`ifdef YSYX_ARB_RR_EN
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   logic [PW-1:0] ptr_q;
   logic [PW-1:0] win_idx;
   logic [PW-1:0] ptr_d;

   ysyx_23060221_rr_pick #(.N(N), .PW(PW)) u_pick (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (pick)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_q[i]) win_idx = PW'(i);
      end
      ptr_d = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
   end
`else
   assign pick = req & (~req + N'(1));
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         busy_q  <= 1'b0;
`ifdef YSYX_ARB_RR_EN
         ptr_q   <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (|req) begin
                  grant_q <= pick;
                  busy_q  <= 1'b1;
                  // A master holding both AW and AR is sent down the write path first.
                  state_q <= (|(pick & m.awvalid)) ? WR : RD;
               end
            end
            WR, RD: begin
               if (done) begin
                  state_q <= IDLE;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
`ifdef YSYX_ARB_RR_EN
                  ptr_q   <= ptr_d;
`endif
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign grant = grant_q;
   assign busy  = busy_q;

   // Everything not owned by the granted master in the current direction is forced to zero.
   always_comb begin
      s.awvalid = '0;
      s.aw      = '0;
      s.wvalid  = '0;
      s.w       = '0;
      s.bready  = '0;
      s.arvalid = '0;
      s.ar      = '0;
      s.rready  = '0;
      m.awready = '0;
      m.wready  = '0;
      m.bvalid  = '0;
      m.b       = '0;
      m.arready = '0;
      m.rvalid  = '0;
      m.r       = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_q[i] && state_q == WR) begin
            s.awvalid[0]        = m.awvalid[i];
            s.aw                = m.aw[i*AWP +: AWP];
            m.awready[i]        = s.awready[0];
            s.wvalid[0]         = m.wvalid[i];
            s.w                 = m.w[i*WP +: WP];
            m.wready[i]         = s.wready[0];
            m.bvalid[i]         = s.bvalid[0];
            m.b[i*BP +: BP]     = s.b;
            s.bready[0]         = m.bready[i];
         end
         if (grant_q[i] && state_q == RD) begin
            s.arvalid[0]        = m.arvalid[i];
            s.ar                = m.ar[i*AWP +: AWP];
            m.arready[i]        = s.arready[0];
            m.rvalid[i]         = s.rvalid[0];
            m.r[i*RP +: RP]     = s.r;
            s.rready[0]         = m.rready[i];
         end
      end
   end
endmodule

// File: tb/tb_ysyx_23060221_axi_arb_n.sv
// Self-checking bench for the N:1 AXI arbiter; follows YSYX_ARB_RR_EN for the expected policy.
module tb_ysyx_23060221_axi_arb_n;
   import ysyx_23060221_axi_pkg::*;

   localparam int N   = 2;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int IDW = 4;
   localparam int AWP = awp_w(IDW, AW);
   localparam int WP  = wp_w(DW);
   localparam int BP  = bp_w(IDW);
   localparam int RP  = rp_w(IDW, DW);

   logic         clk;
   logic         rst;
   logic [N-1:0] grant;
   logic         busy;

   ysyx_23060221_axi_arb_n_if #(.L(N), .AW(AW), .DW(DW), .IDW(IDW)) m_if ();
   ysyx_23060221_axi_arb_n_if #(.L(1), .AW(AW), .DW(DW), .IDW(IDW)) s_if ();

   ysyx_23060221_axi_arb_n #(.N(N), .AW(AW), .DW(DW), .IDW(IDW)) dut (
      .clk   (clk),
      .rst   (rst),
      .m     (m_if),
      .s     (s_if),
      .grant (grant),
      .busy  (busy)
   );

   int errors = 0;
   int checks = 0;
   int model_ptr = 0;
   logic [N-1:0]   pend_aw, pend_ar;
   logic [AWP-1:0] aw_pl [N];
   logic [AWP-1:0] ar_pl [N];
   int             wlen [N];
   int             rlen [N];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   // Reference policy: scan from the start point upward with wrap; fixed priority starts at 0.
   function automatic int model_pick(input logic [N-1:0] req);
      int start;
`ifdef YSYX_ARB_RR_EN
      start = model_ptr;
`else
      start = 0;
`endif
      for (int k = 0; k < N; k++) begin
         if (req[(start + k) % N]) return (start + k) % N;
      end
      return -1;
   endfunction

   task automatic clear_inputs();
      m_if.awvalid = '0; m_if.aw = '0; m_if.wvalid = '0; m_if.w = '0; m_if.bready = '0;
      m_if.arvalid = '0; m_if.ar = '0; m_if.rready = '0;
      s_if.awready = '0; s_if.wready = '0; s_if.bvalid = '0; s_if.b = '0;
      s_if.arready = '0; s_if.rvalid = '0; s_if.r = '0;
      pend_aw = '0; pend_ar = '0;
   endtask

   // kind: 0 write, 1 read, 2 both
   task automatic raise_req(input int who, input int kind, input int lw, input int lr);
      if (kind != 1) begin
         aw_pl[who] = {IDW'($urandom), 8'(lw), 3'd2, 2'd1, AW'($urandom)};
         wlen[who] = lw;
         pend_aw[who] = 1'b1;
         m_if.awvalid[who] = 1'b1;
         m_if.aw[who*AWP +: AWP] = aw_pl[who];
      end
      if (kind != 0) begin
         ar_pl[who] = {IDW'($urandom), 8'(lr), 3'd2, 2'd1, AW'($urandom)};
         rlen[who] = lr;
         pend_ar[who] = 1'b1;
         m_if.arvalid[who] = 1'b1;
         m_if.ar[who*AWP +: AWP] = ar_pl[who];
      end
   endtask

   task automatic do_wr(input int w, input int stall);
      int b = 0;
      int cyc = 0;
      bit aw_done = 0;
      int len;
      logic [WP-1:0] beat;
      logic [BP-1:0] bresp;
      logic [N-1:0]  eg;
      len = wlen[w];
      eg = '0; eg[w] = 1'b1;
      s_if.wready = 1'b1;
      while (!aw_done || b <= len) begin
         beat = '0;
         if (b <= len) beat = {(b == len), {(DW/8){1'b1}}, DW'($urandom)};
         m_if.wvalid[w] = (b <= len);
         m_if.w[w*WP +: WP] = beat;
         s_if.awready = (cyc >= 1);
         #1;
         checks++;
         if (s_if.awvalid[0] !== !aw_done || s_if.wvalid[0] !== (b <= len) || s_if.w !== beat) begin
            errors++;
            $display("FAIL wr_fwd m%0d beat %0d: awvalid=%b wvalid=%b w=%h, required awvalid=%b wvalid=%b w=%h",
                     w, b, s_if.awvalid[0], s_if.wvalid[0], s_if.w, !aw_done, (b <= len), beat);
         end
         checks++;
         if ((!aw_done && s_if.aw !== aw_pl[w]) || s_if.arvalid[0] !== 1'b0 || m_if.arready !== '0) begin
            errors++;
            $display("FAIL wr_aw m%0d: s_aw=%h s_arvalid=%b m_arready=%b, required aw=%h arvalid=0 arready=0",
                     w, s_if.aw, s_if.arvalid[0], m_if.arready, aw_pl[w]);
         end
         @(negedge clk);
         if (!aw_done && s_if.awready[0]) begin
            aw_done = 1;
            m_if.awvalid[w] = 1'b0;
            m_if.aw[w*AWP +: AWP] = '0;
            pend_aw[w] = 1'b0;
         end
         if (b <= len) b++;
         cyc++;
      end
      m_if.wvalid[w] = 1'b0; m_if.w[w*WP +: WP] = '0;
      s_if.awready = '0; s_if.wready = '0;
      for (int k = 0; k < stall; k++) begin
         #1;
         checks++;
         if (grant !== eg || m_if.bvalid !== '0 || s_if.arvalid[0] !== 1'b0) begin
            errors++;
            $display("FAIL wr_stall cycle %0d: grant=%b bvalid=%b s_arvalid=%b, required grant=%b bvalid=0 arvalid=0",
                     k, grant, m_if.bvalid, s_if.arvalid[0], eg);
         end
         for (int j = 0; j < N; j++) begin
            if (j != w) begin
               checks++;
               if (m_if.awready[j] !== 1'b0 || m_if.arready[j] !== 1'b0) begin
                  errors++;
                  $display("FAIL stall_ready m%0d: awready=%b arready=%b, required 0 and 0",
                           j, m_if.awready[j], m_if.arready[j]);
               end
            end
         end
         @(negedge clk);
      end
      bresp = {aw_pl[w][AWP-1 -: IDW], 2'($urandom)};
      s_if.bvalid = 1'b1; s_if.b = bresp; m_if.bready[w] = 1'b1;
      #1;
      checks++;
      if (m_if.bvalid[w] !== 1'b1 || m_if.b[w*BP +: BP] !== bresp || s_if.bready[0] !== 1'b1) begin
         errors++;
         $display("FAIL wr_b m%0d: bvalid=%b b=%h s_bready=%b, required 1 %h 1",
                  w, m_if.bvalid[w], m_if.b[w*BP +: BP], s_if.bready[0], bresp);
      end
      checks++;
      if ((m_if.bvalid & ~eg) !== '0 || (m_if.b & ~({{(N*BP-BP){1'b0}}, {BP{1'b1}}} << (w*BP))) !== '0) begin
         errors++;
         $display("FAIL wr_b_gate: bvalid=%b b=%h, required only master %0d active", m_if.bvalid, m_if.b, w);
      end
      @(negedge clk);
      s_if.bvalid = 1'b0; s_if.b = '0; m_if.bready[w] = 1'b0;
   endtask

   task automatic do_rd(input int w, input int stall);
      logic [RP-1:0]  beat;
      logic [IDW-1:0] id;
      logic [N-1:0]   eg;
      int len;
      len = rlen[w];
      id = ar_pl[w][AWP-1 -: IDW];
      eg = '0; eg[w] = 1'b1;
      s_if.arready = 1'b1;
      #1;
      checks++;
      if (s_if.arvalid[0] !== 1'b1 || s_if.ar !== ar_pl[w] || m_if.arready[w] !== 1'b1 ||
          s_if.awvalid[0] !== 1'b0 || m_if.awready !== '0) begin
         errors++;
         $display("FAIL rd_ar m%0d: arvalid=%b ar=%h arready=%b s_awvalid=%b m_awready=%b, required 1 %h 1 0 0",
                  w, s_if.arvalid[0], s_if.ar, m_if.arready[w], s_if.awvalid[0], m_if.awready, ar_pl[w]);
      end
      @(negedge clk);
      m_if.arvalid[w] = 1'b0; m_if.ar[w*AWP +: AWP] = '0; pend_ar[w] = 1'b0;
      s_if.arready = '0;
      for (int k = 0; k < stall; k++) begin
         #1;
         checks++;
         if (grant !== eg || m_if.rvalid !== '0) begin
            errors++;
            $display("FAIL rd_stall cycle %0d: grant=%b rvalid=%b, required grant=%b rvalid=0",
                     k, grant, m_if.rvalid, eg);
         end
         for (int j = 0; j < N; j++) begin
            if (j != w) begin
               checks++;
               if (m_if.awready[j] !== 1'b0 || m_if.arready[j] !== 1'b0) begin
                  errors++;
                  $display("FAIL stall_ready m%0d: awready=%b arready=%b, required 0 and 0",
                           j, m_if.awready[j], m_if.arready[j]);
               end
            end
         end
         @(negedge clk);
      end
      for (int b = 0; b <= len; b++) begin
         beat = {id, (b == len), 2'b00, DW'($urandom)};
         s_if.rvalid = 1'b1; s_if.r = beat; m_if.rready[w] = 1'b1;
         #1;
         checks++;
         if (m_if.rvalid[w] !== 1'b1 || m_if.r[w*RP +: RP] !== beat || s_if.rready[0] !== 1'b1) begin
            errors++;
            $display("FAIL rd_beat m%0d beat %0d: rvalid=%b r=%h s_rready=%b, required 1 %h 1",
                     w, b, m_if.rvalid[w], m_if.r[w*RP +: RP], s_if.rready[0], beat);
         end
         checks++;
         if ((m_if.rvalid & ~eg) !== '0 || (m_if.r & ~({{(N*RP-RP){1'b0}}, {RP{1'b1}}} << (w*RP))) !== '0) begin
            errors++;
            $display("FAIL rd_gate beat %0d: rvalid=%b r=%h, required only master %0d active",
                     b, m_if.rvalid, m_if.r, w);
         end
         @(negedge clk);
      end
      s_if.rvalid = 1'b0; s_if.r = '0; m_if.rready[w] = 1'b0;
   endtask

   // Entered at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic serve(input int exp_w, input int st_lo, input int st_hi, output int w);
      logic [N-1:0] eg;
      int stall;
      checks++;
      if (grant !== '0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle: grant=%b busy=%b, required 0 0", grant, busy);
      end
      w = model_pick(pend_aw | pend_ar);
      eg = '0; eg[w] = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (grant !== eg || busy !== 1'b1) begin
         errors++;
         $display("FAIL grant: grant=%b busy=%b, required %b 1", grant, busy, eg);
      end
      if (exp_w >= 0) begin
         checks++;
         if (grant[exp_w] !== 1'b1) begin
            errors++;
            $display("FAIL grant_seq: grant=%b, required master %0d", grant, exp_w);
         end
      end
      stall = $urandom_range(st_hi, st_lo);
      if (pend_aw[w]) do_wr(w, stall);
      else            do_rd(w, stall);
      model_ptr = (w + 1) % N;
   endtask

   task automatic run_until_idle(input int st_lo, input int st_hi);
      int w;
      int guard = 0;
      while ((pend_aw | pend_ar) != '0 && guard < 16) begin
         serve(-1, st_lo, st_hi, w);
         guard++;
      end
      checks++;
      if ((pend_aw | pend_ar) != '0) begin
         errors++;
         $display("FAIL drain: pending aw=%b ar=%b, required none", pend_aw, pend_ar);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      model_ptr = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (grant !== '0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: grant=%b busy=%b, required 0 0", grant, busy);
      end
      checks++;
      if ({s_if.awvalid, s_if.wvalid, s_if.arvalid, s_if.bready, s_if.rready} !== '0) begin
         errors++;
         $display("FAIL reset_slave_side: aw/w/ar valid, b/r ready=%b, required 0",
                  {s_if.awvalid, s_if.wvalid, s_if.arvalid, s_if.bready, s_if.rready});
      end
      checks++;
      if ({m_if.awready, m_if.wready, m_if.arready, m_if.bvalid, m_if.rvalid} !== '0) begin
         errors++;
         $display("FAIL reset_master_side: readies/valids=%b, required 0",
                  {m_if.awready, m_if.wready, m_if.arready, m_if.bvalid, m_if.rvalid});
      end
      rst = 1'b0;
   endtask

   task automatic test_read_burst();
      int w;
      @(negedge clk);
      raise_req(1, 1, 0, 3);
      serve(1, 0, 0, w);
   endtask

   task automatic test_contention();
      int w;
      int exp_w;
      raise_req(0, 1, 0, 0);
      raise_req(1, 1, 0, 0);
      serve(0, 0, 0, w);
      serve(1, 0, 0, w);
      raise_req(0, 1, 0, 0);
      raise_req(1, 1, 0, 0);
      for (int r = 0; r < 4; r++) begin
`ifdef YSYX_ARB_RR_EN
         exp_w = r % 2;
`else
         exp_w = 0;
`endif
         serve(exp_w, 0, 1, w);
         raise_req(w, 1, 0, $urandom_range(2, 0));
      end
      run_until_idle(0, 1);
   endtask

   task automatic test_wr_first_stall();
      int w;
      raise_req(0, 2, 1, 2);
      raise_req(1, 1, 0, 1);
      serve(0, 5, 5, w);
      run_until_idle(0, 2);
   endtask

   task automatic test_random();
      int set;
      for (int it = 0; it < 12; it++) begin
         set = $urandom_range(3, 1);
         for (int j = 0; j < N; j++) begin
            if (set[j]) raise_req(j, $urandom_range(2, 0), $urandom_range(3, 0), $urandom_range(3, 0));
         end
         run_until_idle(0, 3);
      end
   endtask

   task automatic test_reset_mid();
      int w;
      logic [IDW-1:0] id;
      raise_req(0, 1, 0, 0);
      run_until_idle(0, 0);
      raise_req(1, 1, 0, 3);
      id = ar_pl[1][AWP-1 -: IDW];
      @(negedge clk); #1;
      checks++;
      if (grant !== 2'b10) begin
         errors++;
         $display("FAIL mid_grant: grant=%b, required 10", grant);
      end
      s_if.arready = 1'b1;
      @(negedge clk);
      m_if.arvalid[1] = 1'b0; m_if.ar[AWP +: AWP] = '0; pend_ar[1] = 1'b0; s_if.arready = '0;
      m_if.rready[1] = 1'b1;
      s_if.rvalid = 1'b1; s_if.r = {id, 1'b0, 2'b00, DW'($urandom)};
      @(negedge clk);
      s_if.r = {id, 1'b0, 2'b00, DW'($urandom)};
      #2 rst = 1'b1;
      #1;
      checks++;
      if (grant !== '0 || busy !== 1'b0 || m_if.rvalid !== '0 || s_if.rready[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: grant=%b busy=%b rvalid=%b s_rready=%b, required all 0",
                  grant, busy, m_if.rvalid, s_if.rready[0]);
      end
      checks++;
      if ({s_if.awvalid, s_if.wvalid, s_if.arvalid, s_if.bready, m_if.awready, m_if.wready, m_if.arready, m_if.bvalid} !== '0) begin
         errors++;
         $display("FAIL mid_reset_other: signals=%b, required 0",
                  {s_if.awvalid, s_if.wvalid, s_if.arvalid, s_if.bready, m_if.awready, m_if.wready, m_if.arready, m_if.bvalid});
      end
      @(negedge clk); #1;
      checks++;
      if (m_if.rvalid !== '0) begin
         errors++;
         $display("FAIL mid_drop: rvalid=%b, required 0", m_if.rvalid);
      end
      clear_inputs();
      model_ptr = 0;
      @(negedge clk);
      rst = 1'b0;
      raise_req(0, 1, 0, 1);
      raise_req(1, 1, 0, 1);
      serve(0, 0, 0, w);
      run_until_idle(0, 0);
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_read_burst();
      test_contention();
      test_wr_first_stall();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
